// File: rtl/mps_sfp_pkg.sv
// rtl/mps_sfp_pkg.sv - shared state encodings and default widths for the Aurora frame bridge
package mps_sfp_pkg;

    localparam int DEF_TDATA_WIDTH     = 64;
    localparam int DEF_NUMBER_OF_FRAME = 2;
    localparam int DEF_RX_TIMEOUT      = 1024;

    typedef enum logic {
        TX_IDLE = 1'b0,
        TX_SEND = 1'b1
    } tx_state_e;

    typedef enum logic {
        RX_COLLECT = 1'b0,
        RX_DISCARD = 1'b1
    } rx_state_e;

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/aurora_frame_rx.sv
// rtl/aurora_frame_rx.sv - Aurora RX word collector with frame validation and inter-word timeout
module aurora_frame_rx
    import mps_sfp_pkg::*;
#(
    parameter int W       = DEF_TDATA_WIDTH,
    parameter int N       = DEF_NUMBER_OF_FRAME,
    parameter int F       = W * N,
    parameter int TIMEOUT = DEF_RX_TIMEOUT
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic [W-1:0] s_axis_tdata,
    input  logic         s_axis_tvalid,
    input  logic         s_axis_tlast,
    input  logic         i_channel_up,
    output logic [F-1:0] o_stream_data,
    output logic         o_rx_end_flag,
    output logic         o_rx_err,
    output logic [15:0]  o_rx_frame_cnt
);

    localparam int IW = idx_width(N);
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [IW-1:0] LAST_IDX = IW'(N - 1);
    localparam logic [IW-1:0] ONE_IDX  = IW'(1);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);
    localparam logic [TW-1:0] ONE_TMO  = TW'(1);

    rx_state_e     state_q, state_d;
    logic [IW-1:0] idx_q, idx_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic [F-1:0]  shadow_q, shadow_d;
    logic [F-1:0]  data_q, data_d;
    logic          end_q, end_d;
    logic          err_q, err_d;
    logic [15:0]   cnt_q, cnt_d;

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        tmo_d    = tmo_q;
        shadow_d = shadow_q;
        data_d   = data_q;
        end_d    = 1'b0;
        err_d    = 1'b0;
        cnt_d    = cnt_q;
        if (!i_channel_up) begin
            state_d = RX_COLLECT;
            idx_d   = '0;
            tmo_d   = '0;
        end else if (s_axis_tvalid) begin
            tmo_d = '0;
            if (state_q == RX_DISCARD) begin
                if (s_axis_tlast) state_d = RX_COLLECT;
            end else begin
                shadow_d[int'(idx_q)*W +: W] = s_axis_tdata;
                if (s_axis_tlast) begin
                    idx_d = '0;
                    if (idx_q == LAST_IDX) begin
                        data_d = shadow_d;
                        end_d  = 1'b1;
                        cnt_d  = cnt_q + 16'd1;
                    end else begin
                        err_d = 1'b1;
                    end
                end else if (idx_q == LAST_IDX) begin
                    // Overlong frame: drop the rest up to its tlast word.
                    err_d   = 1'b1;
                    idx_d   = '0;
                    state_d = RX_DISCARD;
                end else begin
                    idx_d = idx_q + ONE_IDX;
                end
            end
        end else if (idx_q != '0) begin
            if (tmo_q == TMO_LAST) begin
                err_d = 1'b1;
                idx_d = '0;
                tmo_d = '0;
            end else begin
                tmo_d = tmo_q + ONE_TMO;
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q  <= RX_COLLECT;
            idx_q    <= '0;
            tmo_q    <= '0;
            shadow_q <= '0;
            data_q   <= '0;
            end_q    <= 1'b0;
            err_q    <= 1'b0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            tmo_q    <= tmo_d;
            shadow_q <= shadow_d;
            data_q   <= data_d;
            end_q    <= end_d;
            err_q    <= err_d;
            cnt_q    <= cnt_d;
        end
    end

    assign o_stream_data  = data_q;
    assign o_rx_end_flag  = end_q;
    assign o_rx_err       = err_q;
    assign o_rx_frame_cnt = cnt_q;

endmodule

// File: rtl/aurora_frame_bridge.sv
// rtl/aurora_frame_bridge.sv - frame <-> Aurora AXI-Stream bridge: TX serializer FSM plus RX collector
module aurora_frame_bridge
    import mps_sfp_pkg::*;
#(
    parameter int C_AXIS_TDATA_WIDTH = DEF_TDATA_WIDTH,
    parameter int C_NUMBER_OF_FRAME  = DEF_NUMBER_OF_FRAME,
    parameter int C_DATA_FRAME_BIT   = C_AXIS_TDATA_WIDTH * C_NUMBER_OF_FRAME,
    parameter int C_RX_TIMEOUT       = DEF_RX_TIMEOUT
) (
    input  logic                          i_clk,
    input  logic                          i_rst,
    input  logic [C_DATA_FRAME_BIT-1:0]   i_stream_data,
    input  logic                          i_tx_start_flag,
    output logic [C_DATA_FRAME_BIT-1:0]   o_stream_data,
    output logic                          o_rx_end_flag,
    output logic [C_AXIS_TDATA_WIDTH-1:0] m_axis_tdata,
    output logic                          m_axis_tvalid,
    output logic                          m_axis_tlast,
    input  logic                          m_axis_tready,
    input  logic [C_AXIS_TDATA_WIDTH-1:0] s_axis_tdata,
    input  logic                          s_axis_tvalid,
    input  logic                          s_axis_tlast,
    input  logic                          i_channel_up,
    output logic                          o_tx_busy,
    output logic                          o_tx_drop,
    output logic                          o_rx_err,
    output logic [15:0]                   o_rx_frame_cnt
);

    localparam int W  = C_AXIS_TDATA_WIDTH;
    localparam int IW = idx_width(C_NUMBER_OF_FRAME);
    localparam logic [IW-1:0] LAST_IDX = IW'(C_NUMBER_OF_FRAME - 1);
    localparam logic [IW-1:0] ONE_IDX  = IW'(1);

    tx_state_e                   state_q, state_d;
    logic [C_DATA_FRAME_BIT-1:0] frame_q, frame_d;
    logic [IW-1:0]               idx_q, idx_d;
    logic [W-1:0]                tdata_q, tdata_d;
    logic                        tvalid_q, tvalid_d;
    logic                        tlast_q, tlast_d;
    logic                        drop_q, drop_d;
    logic                        start_prev_q, start_prev_d;
    logic                        start_rise;

    assign start_rise = i_tx_start_flag & ~start_prev_q;

    always_comb begin
        state_d      = state_q;
        frame_d      = frame_q;
        idx_d        = idx_q;
        tdata_d      = tdata_q;
        tvalid_d     = tvalid_q;
        tlast_d      = tlast_q;
        drop_d       = 1'b0;
        start_prev_d = i_tx_start_flag;
        if (state_q == TX_IDLE) begin
            if (start_rise) begin
                if (i_channel_up) begin
                    state_d  = TX_SEND;
                    frame_d  = i_stream_data;
                    idx_d    = '0;
                    tvalid_d = 1'b1;
                    tdata_d  = i_stream_data[W-1:0];
                    tlast_d  = (C_NUMBER_OF_FRAME == 1);
                end else begin
                    drop_d = 1'b1;
                end
            end
        end else begin
            drop_d = start_rise;
            if (!i_channel_up) begin
                state_d  = TX_IDLE;
                tvalid_d = 1'b0;
                tlast_d  = 1'b0;
                drop_d   = 1'b1;
            end else if (m_axis_tready) begin
                if (idx_q == LAST_IDX) begin
                    state_d  = TX_IDLE;
                    tvalid_d = 1'b0;
                    tlast_d  = 1'b0;
                end else begin
                    idx_d   = idx_q + ONE_IDX;
                    tdata_d = frame_q[int'(idx_d)*W +: W];
                    tlast_d = (idx_d == LAST_IDX);
                end
            end
        end
    end

    // Edge register resets high so a flag held through reset is not seen as a request.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q      <= TX_IDLE;
            frame_q      <= '0;
            idx_q        <= '0;
            tdata_q      <= '0;
            tvalid_q     <= 1'b0;
            tlast_q      <= 1'b0;
            drop_q       <= 1'b0;
            start_prev_q <= 1'b1;
        end else begin
            state_q      <= state_d;
            frame_q      <= frame_d;
            idx_q        <= idx_d;
            tdata_q      <= tdata_d;
            tvalid_q     <= tvalid_d;
            tlast_q      <= tlast_d;
            drop_q       <= drop_d;
            start_prev_q <= start_prev_d;
        end
    end

    assign m_axis_tdata  = tdata_q;
    assign m_axis_tvalid = tvalid_q;
    assign m_axis_tlast  = tlast_q;
    assign o_tx_busy     = (state_q == TX_SEND);
    assign o_tx_drop     = drop_q;

    aurora_frame_rx #(
        .W       (C_AXIS_TDATA_WIDTH),
        .N       (C_NUMBER_OF_FRAME),
        .F       (C_DATA_FRAME_BIT),
        .TIMEOUT (C_RX_TIMEOUT)
    ) u_rx (
        .i_clk          (i_clk),
        .i_rst          (i_rst),
        .s_axis_tdata   (s_axis_tdata),
        .s_axis_tvalid  (s_axis_tvalid),
        .s_axis_tlast   (s_axis_tlast),
        .i_channel_up   (i_channel_up),
        .o_stream_data  (o_stream_data),
        .o_rx_end_flag  (o_rx_end_flag),
        .o_rx_err       (o_rx_err),
        .o_rx_frame_cnt (o_rx_frame_cnt)
    );

endmodule

// File: tb/tb_aurora_frame_bridge.sv
// tb/tb_aurora_frame_bridge.sv - directed self-checking bench for aurora_frame_bridge
module tb_aurora_frame_bridge;

    localparam int W = 64;
    localparam int F = 128;
    localparam logic [W-1:0] WORD0 = 64'h2222222222222222;
    localparam logic [W-1:0] WORD1 = 64'h1111111111111111;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [F-1:0] i_stream_data = '0;
    logic         i_tx_start_flag = 1'b1;
    logic [F-1:0] o_stream_data;
    logic         o_rx_end_flag;
    logic [W-1:0] m_axis_tdata;
    logic         m_axis_tvalid;
    logic         m_axis_tlast;
    logic         m_axis_tready = 1'b0;
    logic [W-1:0] s_axis_tdata = '0;
    logic         s_axis_tvalid = 1'b0;
    logic         s_axis_tlast = 1'b0;
    logic         i_channel_up = 1'b1;
    logic         o_tx_busy;
    logic         o_tx_drop;
    logic         o_rx_err;
    logic [15:0]  o_rx_frame_cnt;

    int n_checks = 0;
    int n_fail   = 0;
    int hs_cnt   = 0;
    int end_cnt  = 0;
    int err_cnt  = 0;
    int drop_cnt = 0;

    always #5 clk = ~clk;

    aurora_frame_bridge dut (
        .i_clk           (clk),
        .i_rst           (rst),
        .i_stream_data   (i_stream_data),
        .i_tx_start_flag (i_tx_start_flag),
        .o_stream_data   (o_stream_data),
        .o_rx_end_flag   (o_rx_end_flag),
        .m_axis_tdata    (m_axis_tdata),
        .m_axis_tvalid   (m_axis_tvalid),
        .m_axis_tlast    (m_axis_tlast),
        .m_axis_tready   (m_axis_tready),
        .s_axis_tdata    (s_axis_tdata),
        .s_axis_tvalid   (s_axis_tvalid),
        .s_axis_tlast    (s_axis_tlast),
        .i_channel_up    (i_channel_up),
        .o_tx_busy       (o_tx_busy),
        .o_tx_drop       (o_tx_drop),
        .o_rx_err        (o_rx_err),
        .o_rx_frame_cnt  (o_rx_frame_cnt)
    );

    // Inputs change at posedge+2, so the negedge view is what the next posedge samples.
    always @(negedge clk) begin
        if (m_axis_tvalid && m_axis_tready) hs_cnt = hs_cnt + 1;
        end_cnt  = end_cnt + int'(o_rx_end_flag);
        err_cnt  = err_cnt + int'(o_rx_err);
        drop_cnt = drop_cnt + int'(o_tx_drop);
    end

    task automatic check_eq(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic rx_word(input logic [W-1:0] data, input logic last);
        s_axis_tdata  = data;
        s_axis_tvalid = 1'b1;
        s_axis_tlast  = last;
        tick();
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
    endtask

    logic         rdy   [5] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    logic [W-1:0] exp_d [5] = '{WORD0, WORD0, WORD1, WORD1, WORD1};
    logic         exp_l [5] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    int hs0, end0, err0, drop0;

    initial begin
        #3;
        check_eq("rst_tvalid", m_axis_tvalid, 0);
        check_eq("rst_tlast", m_axis_tlast, 0);
        check_eq("rst_tdata", m_axis_tdata, 0);
        check_eq("rst_stream", o_stream_data, 0);
        check_eq("rst_cnt", o_rx_frame_cnt, 0);
        check_eq("rst_busy", o_tx_busy, 0);
        check_eq("rst_pulses", {o_tx_drop, o_rx_err, o_rx_end_flag}, 0);
        tick();
        rst = 1'b0;
        tick();
        tick();
        check_eq("held_flag_no_start", o_tx_busy, 0);
        check_eq("held_flag_no_drop", o_tx_drop, 0);
        i_tx_start_flag = 1'b0;
        tick();

        // Basic frame, tready always high
        i_stream_data   = {WORD1, WORD0};
        m_axis_tready   = 1'b1;
        i_tx_start_flag = 1'b1;
        hs0 = hs_cnt;
        tick();
        i_tx_start_flag = 1'b0;
        check_eq("tx1_w0_valid", m_axis_tvalid, 1);
        check_eq("tx1_w0_data", m_axis_tdata, WORD0);
        check_eq("tx1_w0_last", m_axis_tlast, 0);
        check_eq("tx1_w0_busy", o_tx_busy, 1);
        tick();
        check_eq("tx1_w1_data", m_axis_tdata, WORD1);
        check_eq("tx1_w1_last", m_axis_tlast, 1);
        check_eq("tx1_w1_busy", o_tx_busy, 1);
        tick();
        check_eq("tx1_end_valid", m_axis_tvalid, 0);
        check_eq("tx1_end_busy", o_tx_busy, 0);
        check_eq("tx1_transfers", hs_cnt - hs0, 2);

        // Backpressure pattern 0,1,0,0,1
        m_axis_tready   = 1'b0;
        i_tx_start_flag = 1'b1;
        hs0 = hs_cnt;
        tick();
        i_tx_start_flag = 1'b0;
        for (int i = 0; i < 5; i++) begin
            m_axis_tready = rdy[i];
            check_eq($sformatf("tx2_valid_%0d", i), m_axis_tvalid, 1);
            check_eq($sformatf("tx2_data_%0d", i), m_axis_tdata, exp_d[i]);
            check_eq($sformatf("tx2_last_%0d", i), m_axis_tlast, exp_l[i]);
            tick();
        end
        m_axis_tready = 1'b0;
        check_eq("tx2_end_valid", m_axis_tvalid, 0);
        check_eq("tx2_transfers", hs_cnt - hs0, 2);

        // Start request during SEND, then channel drop mid-SEND
        i_tx_start_flag = 1'b1;
        tick();
        i_tx_start_flag = 1'b0;
        tick();
        i_tx_start_flag = 1'b1;
        tick();
        check_eq("drop_in_send", o_tx_drop, 1);
        check_eq("drop_in_send_busy", o_tx_busy, 1);
        i_tx_start_flag = 1'b0;
        i_channel_up    = 1'b0;
        tick();
        check_eq("chan_drop_valid", m_axis_tvalid, 0);
        check_eq("chan_drop_busy", o_tx_busy, 0);
        check_eq("chan_drop_pulse", o_tx_drop, 1);
        tick();
        check_eq("chan_drop_pulse_end", o_tx_drop, 0);

        // Request while the link is down
        i_tx_start_flag = 1'b1;
        tick();
        check_eq("link_down_drop", o_tx_drop, 1);
        check_eq("link_down_busy", o_tx_busy, 0);
        i_tx_start_flag = 1'b0;
        i_channel_up    = 1'b1;
        tick();

        // RX good frame
        rx_word(64'hA, 1'b0);
        rx_word(64'hB, 1'b1);
        check_eq("rx1_end", o_rx_end_flag, 1);
        check_eq("rx1_data", o_stream_data, {64'hB, 64'hA});
        check_eq("rx1_cnt", o_rx_frame_cnt, 1);
        tick();
        check_eq("rx1_end_pulse", o_rx_end_flag, 0);

        // Short frame, then a good one
        rx_word(64'hC, 1'b1);
        check_eq("rx_short_err", o_rx_err, 1);
        check_eq("rx_short_end", o_rx_end_flag, 0);
        check_eq("rx_short_data", o_stream_data, {64'hB, 64'hA});
        rx_word(64'h1, 1'b0);
        rx_word(64'h2, 1'b1);
        check_eq("rx2_data", o_stream_data, {64'h2, 64'h1});
        check_eq("rx2_cnt", o_rx_frame_cnt, 2);

        // Overlong frame is discarded through its tlast
        rx_word(64'h3, 1'b0);
        rx_word(64'h4, 1'b0);
        check_eq("rx_long_err", o_rx_err, 1);
        rx_word(64'h5, 1'b0);
        rx_word(64'h6, 1'b1);
        check_eq("rx_discard_end", o_rx_end_flag, 0);
        check_eq("rx_discard_data", o_stream_data, {64'h2, 64'h1});
        rx_word(64'h7, 1'b0);
        rx_word(64'h8, 1'b1);
        check_eq("rx3_data", o_stream_data, {64'h8, 64'h7});
        check_eq("rx3_cnt", o_rx_frame_cnt, 3);

        // Inter-word timeout
        rx_word(64'hD, 1'b0);
        err0 = err_cnt;
        repeat (1023) tick();
        check_eq("tmo_not_yet", o_rx_err, 0);
        check_eq("tmo_no_early_err", err_cnt - err0, 0);
        tick();
        check_eq("tmo_err", o_rx_err, 1);
        rx_word(64'hE, 1'b0);
        rx_word(64'hF, 1'b1);
        check_eq("tmo_next_data", o_stream_data, {64'hF, 64'hE});
        check_eq("tmo_next_cnt", o_rx_frame_cnt, 4);

        // Link drop mid-frame clears the partial frame silently
        err0 = err_cnt;
        rx_word(64'h9, 1'b0);
        i_channel_up = 1'b0;
        tick();
        i_channel_up = 1'b1;
        rx_word(64'h10, 1'b0);
        rx_word(64'h11, 1'b1);
        check_eq("link_rx_data", o_stream_data, {64'h11, 64'h10});
        check_eq("link_rx_noerr", err_cnt - err0, 0);

        // Reset mid-TX and mid-RX
        m_axis_tready   = 1'b0;
        i_tx_start_flag = 1'b1;
        tick();
        i_tx_start_flag = 1'b0;
        rx_word(64'h20, 1'b0);
        end0  = end_cnt;
        drop0 = drop_cnt;
        rst   = 1'b1;
        #1;
        check_eq("async_rst_cnt", o_rx_frame_cnt, 0);
        check_eq("async_rst_stream", o_stream_data, 0);
        check_eq("async_rst_busy", o_tx_busy, 0);
        tick();
        rst = 1'b0;
        tick();
        rx_word(64'h21, 1'b1);
        check_eq("post_rst_short_err", o_rx_err, 1);
        check_eq("post_rst_short_end", o_rx_end_flag, 0);
        tick();
        check_eq("rst_no_end_pulse", end_cnt - end0, 0);
        check_eq("rst_no_drop_pulse", drop_cnt - drop0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/aurora_frame_bridge.md
AURORA_FRAME_BRIDGE -- requirements
Module: aurora_frame_bridge

Interface
REQ-001 SHALL have parameter C_AXIS_TDATA_WIDTH, default 64, Aurora word width.
REQ-002 SHALL have parameter C_NUMBER_OF_FRAME, default 2, words per frame (N).
REQ-003 SHALL have parameter C_DATA_FRAME_BIT, default C_AXIS_TDATA_WIDTH*C_NUMBER_OF_FRAME, frame bit count (F).
REQ-004 SHALL have parameter C_RX_TIMEOUT, default 1024, maximum cycles between RX words of one frame.
REQ-005 Ports SHALL be, in order:
- i_clk  in  1  sole clock;
- i_rst  in  1  asynchronous, active-high reset;
- i_stream_data  in  F  frame to transmit, from core;
- i_tx_start_flag  in  1  TX request, rising-edge active;
- o_stream_data  out  F  last good received frame, to core;
- o_rx_end_flag  out  1  one-cycle pulse when o_stream_data is updated;
- m_axis_tdata / m_axis_tvalid / m_axis_tlast  out  W/1/1  Aurora TX stream;
- m_axis_tready  in  1  Aurora TX ready;
- s_axis_tdata / s_axis_tvalid / s_axis_tlast  in  W/1/1  Aurora RX stream, no backpressure;
- i_channel_up  in  1  Aurora link status;
- o_tx_busy  out  1  TX frame in progress;
- o_tx_drop  out  1  one-cycle pulse, start request rejected;
- o_rx_err  out  1  one-cycle pulse, RX frame discarded;
- o_rx_frame_cnt  out  16  count of good RX frames, wraps 0xFFFF->0.

Function
REQ-006 TX FSM SHALL have states IDLE, SEND, with SEND entered one cycle after a detected i_tx_start_flag rising edge while in IDLE and i_channel_up=1.
REQ-007 On entry to SEND, i_stream_data SHALL be latched; word k (k=0..N-1) SHALL be bits [k*W+W-1 : k*W], word 0 first.
REQ-008 m_axis_tvalid SHALL be 1 throughout SEND; tdata/tlast SHALL stay stable until the cycle tvalid&tready=1; tlast SHALL be 1 only on word N-1.
REQ-009 After the handshake of word N-1, the FSM SHALL return to IDLE in the next cycle, with tvalid=0.
REQ-010 A rising edge while in SEND, or while i_channel_up=0, SHALL produce o_tx_drop and no transfer.
REQ-011 i_channel_up falling during SEND SHALL force IDLE and tvalid=0 in the next cycle, and SHALL pulse o_tx_drop.
REQ-012 o_tx_busy SHALL equal (state==SEND).
REQ-013 RX SHALL accept a word on every cycle with s_axis_tvalid=1, storing it at word index rx_idx into a shadow buffer, then incrementing rx_idx.
REQ-014 A word with tlast=1 at rx_idx=N-1 SHALL copy the shadow buffer (including this word) to o_stream_data in one cycle, pulse o_rx_end_flag in that same cycle, increment o_rx_frame_cnt, and reset rx_idx=0.
REQ-015 A word with tlast=1 at rx_idx<N-1 SHALL pulse o_rx_err, leave o_stream_data unchanged, and reset rx_idx=0.
REQ-016 A word with tlast=0 at rx_idx=N-1 SHALL pulse o_rx_err and enter DISCARD; in DISCARD, words SHALL be dropped until a tlast word, after which rx_idx=0.
REQ-017 When rx_idx>0 and C_RX_TIMEOUT cycles elapse without a valid word, the partial frame SHALL be dropped, o_rx_err SHALL pulse, and rx_idx SHALL be set to 0.
REQ-018 i_channel_up=0 SHALL hold rx_idx=0, leave DISCARD, and suppress o_rx_err.
REQ-019 o_stream_data SHALL never expose a partially received frame.

Reset
REQ-020 On i_rst=1, asynchronously:
- TX FSM=IDLE;
- m_axis_tvalid=0, m_axis_tlast=0, m_axis_tdata=0;
- o_stream_data=0, o_rx_frame_cnt=0;
- all pulses=0, o_tx_busy=0;
- rx_idx=0, timeout counter=0;
- the edge-detect register=1, so that a held-high flag does not start TX after reset.
REQ-021 Reset asserted mid-frame SHALL abandon the frame with no o_rx_end_flag pulse and no o_tx_drop pulse.

Structure
REQ-022 TX/RX state encodings and the default widths SHALL reside in the shared package mps_sfp_pkg.
REQ-023 The RX path SHALL be one sub-module, aurora_frame_rx; the TX path SHALL stay in the top.

Verification
REQ-024 Channel up, i_stream_data=0x1111..._2222... (word1 0x1111111111111111, word0 0x2222222222222222), start pulse, tready=1 -> word0 then word1 (with tlast) on consecutive cycles, busy for 2 cycles.
REQ-025 Same stimulus with tready toggling 0,1,0,0,1 -> each word held stable until its handshake, and exactly 2 transfers.
REQ-026 RX words 0xA, 0xB (tlast on 0xB) -> o_stream_data={0xB,0xA}, one rx_end pulse, and frame_cnt=1.
REQ-027 RX single word 0xC with tlast -> o_rx_err pulse, o_stream_data still {0xB,0xA}; then a good frame is accepted.
REQ-028 RX word 0xD, then 1024 idle cycles -> o_rx_err pulse, rx_idx=0; the next 2-word frame is accepted.
REQ-029 Start request during SEND, and channel drop mid-SEND -> o_tx_drop pulses and tvalid=0 next cycle; reset mid-RX -> no rx_end pulse.
